uart_pkt_parser: RTL and testbench

Byte-level packet parser between the UART receiver and the address-decoded register/SPI-master stages of ast_upum. It consumes received bytes, frames them as packets (prefix 0xDD, destination address, length, payload, CRC byte) and streams payload bytes tagged with a 7-bit destination address. It reports packet success or failure per packet and recovers from truncated packets with an inter-byte timeout.

---
 rtl/uart_pkt_parser_pkg.sv | 19 +
 rtl/uart_pkt_parser_byte_timeout.sv | 31 +++
 rtl/uart_pkt_parser.sv | 126 ++++++++++++
 tb/tb_uart_pkt_parser.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_parser_pkg.sv
// Shared definitions for the UART packet parser: framing defaults, timeout
// derivation and FSM state encoding.
package uart_pkt_parser_pkg;

  localparam logic [7:0]  DEFAULT_PREFIX = 8'hDD;
  localparam int unsigned SYS_CLK = 100_000_000;
  // Allowed inter-byte gap inside a packet: 1 ms of system clock.
  localparam int unsigned DEFAULT_TIMEOUT_CYC = SYS_CLK / 1000;
  localparam int unsigned TIMEOUT_W = 17;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StLen  = 3'd2,
    StData = 3'd3,
    StCrc  = 3'd4
  } state_e;

endpackage

// File: rtl/uart_pkt_parser_byte_timeout.sv
// Inter-byte timeout counter: cleared on every accepted byte, counts while enabled and
// flags the terminal count.
module byte_timeout
  import uart_pkt_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk_100,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] TermCount = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] count_q;

  always_ff @(posedge clk_100 or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != TermCount)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == TermCount);

endmodule

// File: rtl/uart_pkt_parser.sv
// Frames UART bytes into prefix/addr/len/payload/crc packets and streams the payload
// tagged with a 7-bit destination address.
module uart_pkt_parser
  import uart_pkt_parser_pkg::*;
#(
  parameter logic [7:0]  PREFIX      = DEFAULT_PREFIX,
  parameter bit          CHECK_CRC   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic       clk_100,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] addr,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       data_last,
  output logic       pkt_ok,
  output logic       pkt_err
);

  state_e     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] crc_q, crc_d;
  logic       dv_q, dv_d, dl_q, dl_d, ok_q, ok_d, err_q, err_d;
  logic       expired;

  // Counter is held clear in IDLE so it always starts from zero inside a packet.
  byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_byte_timeout (
    .clk_100(clk_100),
    .n_rst  (n_rst),
    .clear  (rx_valid || (state_q == StIdle)),
    .enable (state_q != StIdle),
    .expired(expired)
  );

  always_ff @(posedge clk_100 or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      dv_q    <= 1'b0;
      dl_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      dv_q    <= dv_d;
      dl_q    <= dl_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    dv_d    = 1'b0;
    dl_d    = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    // A byte arriving on the terminal count takes priority over the timeout.
    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == PREFIX) state_d = StAddr;
        end
        StAddr: begin
          addr_d  = rx_data[6:0];
          crc_d   = rx_data;
          state_d = StLen;
        end
        StLen: begin
          cnt_d = rx_data;
          crc_d = crc_q ^ rx_data;
          if (rx_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          data_d = rx_data;
          dv_d   = 1'b1;
          crc_d  = crc_q ^ rx_data;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            dl_d    = 1'b1;
            state_d = StCrc;
          end
        end
        StCrc: begin
          if (!CHECK_CRC || (rx_data == crc_q)) ok_d = 1'b1;
          else                                  err_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (expired) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  assign addr       = addr_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign data_last  = dl_q;
  assign pkt_ok     = ok_q;
  assign pkt_err    = err_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: one instance without and one with CRC checking,
// both driven by the same byte stream with a short timeout.
module tb_uart_pkt_parser;

  localparam int unsigned TO = 50;

  logic       clk_100 = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic [6:0] a0, a1;
  logic [7:0] d0, d1;
  logic       dv0, dl0, ok0, er0, dv1, dl1, ok1, er1;

  int checks = 0;
  int fails = 0;
  int dv0_n = 0, ok0_n = 0, er0_n = 0, dv1_n = 0, ok1_n = 0, er1_n = 0;

  always #5 clk_100 = ~clk_100;

  uart_pkt_parser #(
    .PREFIX(8'hDD), .CHECK_CRC(1'b0), .TIMEOUT_CYC(TO)
  ) u_dut_nc (
    .clk_100(clk_100), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr(a0), .data(d0), .data_valid(dv0), .data_last(dl0), .pkt_ok(ok0), .pkt_err(er0)
  );

  uart_pkt_parser #(
    .PREFIX(8'hDD), .CHECK_CRC(1'b1), .TIMEOUT_CYC(TO)
  ) u_dut_c (
    .clk_100(clk_100), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr(a1), .data(d1), .data_valid(dv1), .data_last(dl1), .pkt_ok(ok1), .pkt_err(er1)
  );

  always @(negedge clk_100) begin
    dv0_n += int'(dv0); ok0_n += int'(ok0); er0_n += int'(er0);
    dv1_n += int'(dv1); ok1_n += int'(ok1); er1_n += int'(er1);
  end

  // Called at a falling edge; returns at the next falling edge where the byte's strobes show.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_100);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_100);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_100);
    checks++;
    if ({a0, d0, dv0, dl0, ok0, er0, a1, d1, dv1, dl1, ok1, er1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got nc=%h/%h/%b%b%b%b c=%h/%h/%b%b%b%b want all zero",
               a0, d0, dv0, dl0, ok0, er0, a1, d1, dv1, dl1, ok1, er1);
    end
    n_rst = 1'b1;
    @(negedge clk_100);
  endtask

  task automatic test_basic();
    int b_dv = dv0_n, b_ok = ok0_n, b_er = er0_n;
    send(8'hDD); send(8'h08); send(8'h02); send(8'h16);
    checks++;
    if ({dv0, dl0, d0} !== {2'b10, 8'h16}) begin
      fails++; $display("FAIL basic_byte0: got dv/dl/data=%b%b/%h want 10/16", dv0, dl0, d0);
    end
    send(8'h1D);
    checks++;
    if ({dv0, dl0, d0} !== {2'b11, 8'h1D}) begin
      fails++; $display("FAIL basic_byte1: got dv/dl/data=%b%b/%h want 11/1d", dv0, dl0, d0);
    end
    checks++;
    if (a0 !== 7'h08) begin
      fails++; $display("FAIL basic_addr: got %h want 08", a0);
    end
    send(8'hCC);
    checks++;
    if ({ok0, er0} !== 2'b10) begin
      fails++; $display("FAIL basic_ok_nocrc: got ok/err=%b%b want 10", ok0, er0);
    end
    // The checking instance sees crc 08^02^16^1D = 01, not CC.
    checks++;
    if ({ok1, er1} !== 2'b01) begin
      fails++; $display("FAIL basic_err_crc: got ok/err=%b%b want 01", ok1, er1);
    end
    settle();
    checks++;
    if ({dv0_n - b_dv, ok0_n - b_ok, er0_n - b_er} !== {32'd2, 32'd1, 32'd0}) begin
      fails++;
      $display("FAIL basic_counts: got dv=%0d ok=%0d err=%0d want 2 1 0",
               dv0_n - b_dv, ok0_n - b_ok, er0_n - b_er);
    end
  endtask

  task automatic test_crc();
    int b_dv = dv1_n, b_ok = ok1_n, b_er = er1_n;
    send(8'hDD); send(8'h09); send(8'h02); send(8'hA0); send(8'h50); send(8'hFB);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL crc_good: got ok/err=%b%b want 10", ok1, er1);
    end
    send(8'hDD); send(8'h09); send(8'h02); send(8'hA0); send(8'h50); send(8'hCC);
    checks++;
    if ({ok1, er1} !== 2'b01) begin
      fails++; $display("FAIL crc_bad: got ok/err=%b%b want 01", ok1, er1);
    end
    checks++;
    if ({ok0, er0} !== 2'b10) begin
      fails++; $display("FAIL crc_bad_nocheck: got ok/err=%b%b want 10", ok0, er0);
    end
    settle();
    checks++;
    if ({dv1_n - b_dv, ok1_n - b_ok, er1_n - b_er} !== {32'd4, 32'd1, 32'd1}) begin
      fails++;
      $display("FAIL crc_counts: got dv=%0d ok=%0d err=%0d want 4 1 1",
               dv1_n - b_dv, ok1_n - b_ok, er1_n - b_er);
    end
  endtask

  task automatic test_leading_bytes();
    int b_dv = dv1_n, b_ok = ok1_n, b_er = er1_n;
    send(8'h55); send(8'hAA);
    settle();
    checks++;
    if ({dv1_n - b_dv, ok1_n - b_ok, er1_n - b_er} !== {32'd0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL leading_silent: got dv=%0d ok=%0d err=%0d want 0 0 0",
               dv1_n - b_dv, ok1_n - b_ok, er1_n - b_er);
    end
    send(8'hDD); send(8'h13); send(8'h01); send(8'h09);
    checks++;
    if ({dv1, dl1, d1, a1} !== {2'b11, 8'h09, 7'h13}) begin
      fails++;
      $display("FAIL leading_data: got dv/dl/data/addr=%b%b/%h/%h want 11/09/13",
               dv1, dl1, d1, a1);
    end
    send(8'h1B);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL leading_ok: got ok/err=%b%b want 10", ok1, er1);
    end
  endtask

  task automatic test_len_zero();
    int b_dv = dv1_n;
    send(8'hDD); send(8'h0A); send(8'h00);
    checks++;
    if ({ok1, er1, ok0, er0} !== 4'b0101) begin
      fails++; $display("FAIL len0_err: got ok/err c=%b%b nc=%b%b want 01 01", ok1, er1, ok0, er0);
    end
    settle();
    checks++;
    if (dv1_n - b_dv !== 0) begin
      fails++; $display("FAIL len0_nodata: got dv=%0d want 0", dv1_n - b_dv);
    end
    send(8'hDD); send(8'h13); send(8'h01); send(8'h09); send(8'h1B);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL len0_recover: got ok/err=%b%b want 10", ok1, er1);
    end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    send(8'hDD); send(8'h0A); send(8'h02); send(8'hA0);
    checks++;
    if ({dv1, dl1, d1} !== {2'b10, 8'hA0}) begin
      fails++; $display("FAIL timeout_data: got dv/dl/data=%b%b/%h want 10/a0", dv1, dl1, d1);
    end
    for (int i = 1; i < TO; i++) begin
      @(negedge clk_100);
      if (er1 || ok1 || dv1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      fails++; $display("FAIL timeout_early: got early strobe=%b want 0", early);
    end
    @(negedge clk_100);
    checks++;
    if ({er1, er0, ok1} !== 3'b110) begin
      fails++; $display("FAIL timeout_err: got err c/nc ok=%b%b%b want 110", er1, er0, ok1);
    end
    @(negedge clk_100);
    checks++;
    if (er1 !== 1'b0) begin
      fails++; $display("FAIL timeout_width: got err=%b want 0", er1);
    end
    send(8'hDD); send(8'h13); send(8'h01); send(8'h09); send(8'h1B);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL timeout_recover: got ok/err=%b%b want 10", ok1, er1);
    end
  endtask

  task automatic test_byte_wins();
    send(8'hDD); send(8'h0A); send(8'h02); send(8'hA0);
    repeat (TO - 1) @(negedge clk_100);
    // The next byte is sampled on the edge where the counter sits at its terminal count.
    send(8'hB0);
    checks++;
    if ({dv1, dl1, er1, d1} !== {3'b110, 8'hB0}) begin
      fails++;
      $display("FAIL wins_data: got dv/dl/err/data=%b%b%b/%h want 110/b0", dv1, dl1, er1, d1);
    end
    send(8'h18);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL wins_ok: got ok/err=%b%b want 10", ok1, er1);
    end
  endtask

  task automatic test_reset_mid();
    int b_dv, b_ok, b_er;
    send(8'hDD); send(8'h08); send(8'h02); send(8'h16);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({a0, d0, dv0, dl0, ok0, er0, a1, d1, dv1, dl1, ok1, er1} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got nc=%h/%h/%b%b%b%b c=%h/%h/%b%b%b%b want all zero",
               a0, d0, dv0, dl0, ok0, er0, a1, d1, dv1, dl1, ok1, er1);
    end
    @(negedge clk_100);
    n_rst = 1'b1;
    @(negedge clk_100);
    #1;
    b_dv = dv0_n + dv1_n; b_ok = ok0_n + ok1_n; b_er = er0_n + er1_n;
    @(negedge clk_100);
    send(8'h1D); send(8'hCC);
    settle();
    checks++;
    if ({dv0_n + dv1_n - b_dv, ok0_n + ok1_n - b_ok, er0_n + er1_n - b_er}
        !== {32'd0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL midreset_silent: got dv=%0d ok=%0d err=%0d want 0 0 0",
               dv0_n + dv1_n - b_dv, ok0_n + ok1_n - b_ok, er0_n + er1_n - b_er);
    end
    send(8'hDD); send(8'h08); send(8'h02); send(8'h16); send(8'h1D); send(8'hCC);
    checks++;
    if ({ok0, er0, a0, d0} !== {2'b10, 7'h08, 8'h1D}) begin
      fails++;
      $display("FAIL midreset_fresh: got ok/err/addr/data=%b%b/%h/%h want 10/08/1d",
               ok0, er0, a0, d0);
    end
  endtask

  task automatic test_back_to_back();
    send(8'hDD); send(8'h13); send(8'h01); send(8'h09); send(8'h1B);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL b2b_first: got ok/err=%b%b want 10", ok1, er1);
    end
    send(8'hDD); send(8'h25); send(8'h01); send(8'hDD);
    checks++;
    if ({dv1, dl1, d1, a1} !== {2'b11, 8'hDD, 7'h25}) begin
      fails++;
      $display("FAIL b2b_prefix_payload: got dv/dl/data/addr=%b%b/%h/%h want 11/dd/25",
               dv1, dl1, d1, a1);
    end
    // 25^01^DD = F9
    send(8'hF9);
    checks++;
    if ({ok1, er1} !== 2'b10) begin
      fails++; $display("FAIL b2b_second: got ok/err=%b%b want 10", ok1, er1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc();
    test_leading_bytes();
    test_len_zero();
    test_timeout();
    test_byte_wins();
    test_reset_mid();
    test_back_to_back();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
